snake_motion_ctrl: RTL and testbench
====================================

Name: snake_motion_ctrl

Overview:
Upstream game-logic stage for the green body display. It holds the snake head position, direction and length, and generates the periodic move strobe. It detects wall and self collisions and handles food consumption. Its outputs drive the display block's head X/Y, length, enable (step) and died inputs directly. The display's GrnPixels output is fed back here as body occupancy.

Parameters:
TICK_DIV, 12500000, clk cycles between moves (must be >= 2)
INIT_X, 8, head row after reset or restart (0..15)
INIT_Y, 4, head column after reset or restart (0..15)
INIT_LEN, 3, snake length after reset or restart (1..31)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  level; starts a game from IDLE or restarts from DEAD
btn_up  input  1  request direction UP (row x-1)
btn_down  input  1  request direction DOWN (row x+1)
btn_left  input  1  request direction LEFT (column y-1)
btn_right  input  1  request direction RIGHT (column y+1)
food_x  input  4  food row
food_y  input  4  food column
food_valid  input  1  food position is meaningful
body_pixels  input  [15:0][15:0]  occupancy feedback, indexed [x][y]
head_x  output  4  current head row
head_y  output  4  current head column
snake_length  output  5  current length
step  output  1  one-cycle move strobe; head/length already updated when high
ate  output  1  one-cycle pulse, coincident with step, on food eaten
died  output  1  high while in DEAD
running  output  1  high while in RUN

Behaviour:
- Reset (highest priority, any state): state IDLE, head (INIT_X, INIT_Y), length INIT_LEN, committed dir RIGHT, pending dir RIGHT, tick counter 0, step/ate/died/running 0.
- FSM states IDLE, RUN, DEAD.
  - IDLE -> RUN when start=1; counter cleared.
  - RUN -> DEAD on collision.
  - DEAD -> IDLE when start=1; head, length and dirs reinitialised.
  - start is ignored in RUN.
- Tick: in RUN the counter counts 0..TICK_DIV-1. The cycle it equals TICK_DIV-1 is the move cycle; the counter wraps to 0. The counter is held at 0 outside RUN.
- Direction capture, every cycle in RUN:
  - Priority up > down > left > right when several buttons are high.
  - A request exactly opposite to the committed dir is dropped.
  - The accepted request overwrites pending dir.
  - pending is copied to committed at the move cycle, before the next head is computed.
- Next head = head moved one cell in the new committed dir.
- Wall collision: the move would leave 0..15 (x=0 going UP, x=15 DOWN, y=0 LEFT, y=15 RIGHT).
- Self collision: body_pixels[next_x][next_y]=1, sampled in the move cycle. Moving into the cell the tail vacates on this step is also a collision; this is deliberate.
- On collision in the move cycle:
  - Register state DEAD; died=1 from the next cycle.
  - head and length are unchanged; no step, no ate.
  - Death takes precedence over eating.
- On a legal move in the move cycle:
  - Register head<=next and step<=1.
  - If food_valid and next==(food_x, food_y): ate<=1 and length<=length+1, saturating at 31 with ate still pulsed.
  - Result: step, ate, new head and new length are all visible together in the cycle after the move cycle. Latency is 1 cycle from the move cycle.
- step and ate are high exactly one cycle and are never high in IDLE or DEAD.
- All outputs are registered. running=1 iff state RUN.

Optional Feature:
SNAKE_WRAP_EN
- Defined: walls are not collisions; coordinates wrap mod 16 (x=15 DOWN -> 0, y=0 LEFT -> 15). Self collision still applies to the wrapped cell.
- Undefined: wall collision -> DEAD as specified above.

Test Plan:
- TICK_DIV=4, reset then start=1 -> step pulses every 4 cycles; head (8,4)->(8,5)->(8,6); length stays 3; ate=0.
- RUN heading RIGHT, pulse btn_left then btn_down between moves -> LEFT dropped; next step head x+1, y unchanged.
- RIGHT from (8,13), no wrap -> steps to y=14, y=15; next move cycle gives died=1, step=0, head stays (8,15). With SNAKE_WRAP_EN the head goes to (8,0) with step=1.
- food_valid=1, food (8,5), head (8,4) RIGHT -> step and ate high in the same cycle, head (8,5), length 4. At length 31, eating keeps length 31 with ate=1.
- body_pixels[8][6]=1 with head (8,5) RIGHT -> died=1 on the next cycle, no step. A simultaneous food match on (8,6) gives no ate.
- DEAD then start=1 -> IDLE, head (8,4), length 3, died=0. A second start -> RUN. Reset asserted mid-RUN -> IDLE next cycle with all outputs at reset values.

Source files
------------

// File: rtl/snake_motion_ctrl.sv
// snake_motion_ctrl: game-logic front end for the green body display.
// Holds head position, heading and length, generates the periodic move
// strobe, and detects wall / self collisions and food consumption.
// Optional build macro: SNAKE_WRAP_EN (coordinates wrap mod 16, no walls).
module snake_motion_ctrl #(
  parameter int TICK_DIV = 12500000,
  parameter int INIT_X   = 8,
  parameter int INIT_Y   = 4,
  parameter int INIT_LEN = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic [3:0]        food_x,
  input  logic [3:0]        food_y,
  input  logic              food_valid,
  input  logic [15:0][15:0] body_pixels,
  output logic [3:0]        head_x,
  output logic [3:0]        head_y,
  output logic [4:0]        snake_length,
  output logic              step,
  output logic              ate,
  output logic              died,
  output logic              running
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DEAD = 2'd2;

  // Opposite directions differ only in bit 0.
  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_DOWN  = 2'd1;
  localparam logic [1:0] D_LEFT  = 2'd2;
  localparam logic [1:0] D_RIGHT = 2'd3;

  localparam int          CW      = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    cdir, pdir;

  logic       req_vld, acc, move;
  logic [1:0] req_dir, eff_dir;
  logic [3:0] nx, ny;
  logic       wall, hit_self, collide, eat;

  // Button priority encode and reversal filter against the committed heading.
  always_comb begin
    req_vld = btn_up | btn_down | btn_left | btn_right;
    req_dir = D_RIGHT;
    if (btn_up)        req_dir = D_UP;
    else if (btn_down) req_dir = D_DOWN;
    else if (btn_left) req_dir = D_LEFT;
    acc     = req_vld && !((req_dir[1] == cdir[1]) && (req_dir[0] != cdir[0]));
    // A request landing in the move cycle itself is honoured by that move.
    eff_dir = acc ? req_dir : pdir;
    move    = (state == S_RUN) && (cnt == CNT_MAX);
  end

  // Candidate next head; 4-bit arithmetic wraps naturally, walls flag the edge.
  always_comb begin
    nx   = head_x;
    ny   = head_y;
    wall = 1'b0;
    case (eff_dir)
      D_UP:    begin nx = head_x - 4'd1; wall = (head_x == 4'd0);  end
      D_DOWN:  begin nx = head_x + 4'd1; wall = (head_x == 4'd15); end
      D_LEFT:  begin ny = head_y - 4'd1; wall = (head_y == 4'd0);  end
      default: begin ny = head_y + 4'd1; wall = (head_y == 4'd15); end
    endcase
`ifdef SNAKE_WRAP_EN
    wall = 1'b0;
`endif
    // The tail cell is still lit this cycle, so chasing the tail kills too.
    hit_self = body_pixels[nx][ny];
    collide  = wall | hit_self;
    eat      = food_valid && (nx == food_x) && (ny == food_y);
  end

  // Game FSM, tick counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      cdir         <= D_RIGHT;
      pdir         <= D_RIGHT;
      head_x       <= 4'(INIT_X);
      head_y       <= 4'(INIT_Y);
      snake_length <= 5'(INIT_LEN);
      step         <= 1'b0;
      ate          <= 1'b0;
      died         <= 1'b0;
      running      <= 1'b0;
    end else begin
      step <= 1'b0;
      ate  <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        end
        S_RUN: begin
          pdir <= eff_dir;
          cnt  <= move ? '0 : cnt + 1'b1;
          if (move) begin
            cdir <= eff_dir;
            if (collide) begin
              state   <= S_DEAD;
              running <= 1'b0;
              died    <= 1'b1;
            end else begin
              head_x <= nx;
              head_y <= ny;
              step   <= 1'b1;
              if (eat) begin
                ate <= 1'b1;
                if (snake_length != 5'd31) snake_length <= snake_length + 5'd1;
              end
            end
          end
        end
        S_DEAD: begin
          cnt <= '0;
          if (start) begin
            state        <= S_IDLE;
            died         <= 1'b0;
            cdir         <= D_RIGHT;
            pdir         <= D_RIGHT;
            head_x       <= 4'(INIT_X);
            head_y       <= 4'(INIT_Y);
            snake_length <= 5'(INIT_LEN);
          end
        end
        default: begin
          state   <= S_IDLE;
          cnt     <= '0;
          running <= 1'b0;
          died    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_motion_ctrl.sv
// Directed bench for snake_motion_ctrl with a short move period (TICK_DIV=4).
module tb_snake_motion_ctrl;
  logic              clk = 1'b0;
  logic              reset, start;
  logic              btn_up, btn_down, btn_left, btn_right;
  logic [3:0]        food_x, food_y;
  logic              food_valid;
  logic [15:0][15:0] body_pixels;
  logic [3:0]        head_x, head_y;
  logic [4:0]        snake_length;
  logic              step, ate, died, running;

  int total = 0;
  int bad   = 0;

  snake_motion_ctrl #(.TICK_DIV(4), .INIT_X(8), .INIT_Y(4), .INIT_LEN(3)) dut (
    .clk(clk), .reset(reset), .start(start),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .body_pixels(body_pixels),
    .head_x(head_x), .head_y(head_y), .snake_length(snake_length),
    .step(step), .ate(ate), .died(died), .running(running)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance until step is seen, bounded; returns cycles taken.
  task automatic wait_step(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (step !== 1'b1 && n < 20);
    if (n >= 20) chk("step_timeout", 0, 1);
  endtask

  task automatic set_btn(input int d);
    btn_up    = (d == 0);
    btn_down  = (d == 1);
    btn_left  = (d == 2);
    btn_right = (d == 3);
  endtask

  initial begin
    int n;
    int ex, ey, el, d;
    reset = 1'b1; start = 1'b0;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    food_x = 0; food_y = 0; food_valid = 0; body_pixels = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_hx", head_x, 8);
    chk("rst_hy", head_y, 4);
    chk("rst_len", snake_length, 3);
    chk("rst_step", step, 0);
    chk("rst_ate", ate, 0);
    chk("rst_died", died, 0);
    chk("rst_run", running, 0);

    // Start and watch two moves to the right.
    start = 1'b1; tick(); start = 1'b0;
    chk("start_run", running, 1);
    wait_step(n);
    chk("move1_period", n, 4);
    chk("move1_hx", head_x, 8);
    chk("move1_hy", head_y, 5);
    chk("move1_ate", ate, 0);
    tick();
    chk("step_pulse_len", step, 0);
    wait_step(n);
    chk("move2_period", n, 3);
    chk("move2_hy", head_y, 6);
    chk("move2_len", snake_length, 3);

    // LEFT is a reversal and gets dropped; DOWN is accepted.
    btn_left = 1; tick(); btn_left = 0;
    btn_down = 1; tick(); btn_down = 0;
    wait_step(n);
    chk("turn_period", n, 2);
    chk("turn_hx", head_x, 9);
    chk("turn_hy", head_y, 6);

    // Turn right and run into the east wall.
    btn_right = 1; tick(); btn_right = 0;
    wait_step(n);
    chk("east_hy7", head_y, 7);
    for (int i = 8; i <= 15; i++) begin
      wait_step(n);
      chk("east_hy", head_y, i);
    end
    chk("east_died_early", died, 0);
    tick(); tick(); tick();
    chk("wall_pre_died", died, 0);
    tick();
    chk("wall_died", died, 1);
    chk("wall_step", step, 0);
    chk("wall_run", running, 0);
    chk("wall_hx", head_x, 9);
    chk("wall_hy", head_y, 15);
    tick();
    chk("dead_hold", died, 1);

    // Restart: DEAD -> IDLE -> RUN.
    start = 1'b1; tick(); start = 1'b0;
    chk("idle_died", died, 0);
    chk("idle_run", running, 0);
    chk("idle_hx", head_x, 8);
    chk("idle_hy", head_y, 4);
    chk("idle_len", snake_length, 3);
    start = 1'b1; tick(); start = 1'b0;
    chk("rerun", running, 1);

    // Eat food at (8,5).
    food_valid = 1; food_x = 8; food_y = 5;
    wait_step(n);
    chk("eat_period", n, 4);
    chk("eat_ate", ate, 1);
    chk("eat_hy", head_y, 5);
    chk("eat_len", snake_length, 4);
    tick();
    chk("eat_pulse", ate, 0);

    // Body ahead at (8,6) with food there too: death wins, no eat.
    food_x = 8; food_y = 6;
    body_pixels[8][6] = 1'b1;
    tick(); tick(); tick();
    chk("self_died", died, 1);
    chk("self_step", step, 0);
    chk("self_ate", ate, 0);
    chk("self_hy", head_y, 5);
    chk("self_len", snake_length, 4);
    body_pixels = '0;

    // Restart and grow around a 2x2 loop until length saturates.
    start = 1'b1; tick(); tick(); start = 1'b0;
    chk("loop_run", running, 1);
    ex = 8; ey = 4; el = 3;
    for (int i = 0; i < 30; i++) begin
      d = (i % 4 == 0) ? 3 : (i % 4 == 1) ? 1 : (i % 4 == 2) ? 2 : 0;
      case (d)
        0: ex = ex - 1;
        1: ex = ex + 1;
        2: ey = ey - 1;
        default: ey = ey + 1;
      endcase
      food_x = 4'(ex); food_y = 4'(ey);
      set_btn(d);
      wait_step(n);
      set_btn(-1);
      if (el < 31) el = el + 1;
      chk("loop_hx", head_x, ex);
      chk("loop_hy", head_y, ey);
      chk("loop_ate", ate, 1);
      chk("loop_len", snake_length, el);
    end
    chk("sat_len", snake_length, 31);
    food_valid = 0;

    // Reset mid-run.
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mrst_run", running, 0);
    chk("mrst_hx", head_x, 8);
    chk("mrst_hy", head_y, 4);
    chk("mrst_len", snake_length, 3);
    chk("mrst_step", step, 0);
    chk("mrst_ate", ate, 0);
    chk("mrst_died", died, 0);
    tick(); tick(); tick(); tick(); tick();
    chk("idle_no_step", step, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
